// File: rtl/bridge_rx_burst.sv
// bridge_rx_burst: parses an ASCII hex byte stream into bus reads, writes and counted burst reads.
module bridge_rx_burst #(
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 16,
    parameter int BURST_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            data_i,
    input  logic                  valid_i,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  rw_o,
    output logic                  valid_o,
    output logic                  busy_o,
    output logic                  err_o
);
    localparam int AD = ADDR_WIDTH / 4;
    localparam int DD = DATA_WIDTH / 4;
    localparam int BD = BURST_WIDTH / 4;
    localparam int MD = AD > DD ? (AD > BD ? AD : BD) : (DD > BD ? DD : BD);
    localparam int CW = $clog2(MD + 1);
    typedef enum logic [2:0] {IDLE, ADDR, DATA, COUNT, EOL, BURST} state_t;
    typedef enum logic [1:0] {CMD_R, CMD_W, CMD_B} cmd_t;
    state_t                 state_q;
    cmd_t                   cmd_q;
    logic [CW-1:0]          dig_q;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_out_q;
    logic [DATA_WIDTH-1:0]  data_q, data_out_q;
    logic [BURST_WIDTH-1:0] cnt_q, rem_q;
    logic                   rw_q, valid_q, busy_q, err_q;
    logic                   dec_d, up_d, lo_d, hex_d, eol_d, cmd_ok_d, last_d;
    logic [3:0]             nib_d;
    cmd_t                   cmd_d;
    state_t                 next_d;
    always_comb begin
        dec_d    = data_i >= 8'h30 && data_i <= 8'h39;
        up_d     = data_i >= 8'h41 && data_i <= 8'h46;
        lo_d     = data_i >= 8'h61 && data_i <= 8'h66;
        hex_d    = dec_d || up_d || lo_d;
        nib_d    = (up_d || lo_d) ? data_i[3:0] + 4'd9 : data_i[3:0];
        eol_d    = data_i == 8'h0D || data_i == 8'h0A;
        cmd_ok_d = data_i == "R" || data_i == "W" || data_i == "B";
        cmd_d    = data_i == "W" ? CMD_W : data_i == "B" ? CMD_B : CMD_R;
        last_d   = state_q == ADDR ? dig_q == CW'(AD - 1) :
                   state_q == DATA ? dig_q == CW'(DD - 1) : dig_q == CW'(BD - 1);
        next_d   = state_q != ADDR ? EOL : cmd_q == CMD_W ? DATA : cmd_q == CMD_B ? COUNT : EOL;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cmd_q      <= CMD_R;
            dig_q      <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            cnt_q      <= '0;
            rem_q      <= '0;
            addr_out_q <= '0;
            data_out_q <= '0;
            rw_q       <= 1'b0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                IDLE: if (valid_i) begin
                    if (cmd_ok_d) begin
                        cmd_q   <= cmd_d;
                        state_q <= ADDR;
                        dig_q   <= '0;
                        addr_q  <= '0;
                        data_q  <= '0;
                        cnt_q   <= '0;
                    end else if (!eol_d) begin
                        err_q <= 1'b1;
                    end
                end
                ADDR, DATA, COUNT: if (valid_i) begin
                    if (!hex_d) begin
                        err_q   <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        dig_q <= last_d ? '0 : dig_q + CW'(1);
                        if (state_q == ADDR) addr_q <= (addr_q << 4) | ADDR_WIDTH'(nib_d);
                        if (state_q == DATA) data_q <= (data_q << 4) | DATA_WIDTH'(nib_d);
                        if (state_q == COUNT) cnt_q <= (cnt_q << 4) | BURST_WIDTH'(nib_d);
                        if (last_d) state_q <= next_d;
                    end
                end
                EOL: if (valid_i) begin
                    state_q <= IDLE;
                    if (!eol_d || (cmd_q == CMD_B && cnt_q == '0)) begin
                        err_q <= 1'b1;
                    end else begin
                        valid_q    <= 1'b1;
                        addr_out_q <= addr_q;
                        rw_q       <= cmd_q == CMD_W;
                        data_out_q <= cmd_q == CMD_W ? data_q : '0;
                        if (cmd_q == CMD_B) begin
                            busy_q  <= 1'b1;
                            rem_q   <= cnt_q - BURST_WIDTH'(1);
                            state_q <= BURST;
                        end
                    end
                end
                BURST: begin
                    err_q <= valid_i;
                    if (rem_q == '0) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        valid_q    <= 1'b1;
                        addr_out_q <= addr_out_q + ADDR_WIDTH'(1);
                        rem_q      <= rem_q - BURST_WIDTH'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign addr_o  = addr_out_q;
    assign data_o  = data_out_q;
    assign rw_o    = rw_q;
    assign valid_o = valid_q;
    assign busy_o  = busy_q;
    assign err_o   = err_q;
endmodule
